cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) between the execute-stage functional units (alu, branch_calculation, multiply, load_alu, store).
- Each FU pushes a completed result (destination tag + value) into a one-entry holding buffer.
- A round-robin arbiter selects one buffered result per cycle into a registered CDB output, with back-pressure from the CDB consumer and a global flush on mispredict.

---
 rtl/cdb_arbiter_pkg.sv | 28 ++
 rtl/cdb_arbiter_rr_arbiter.sv | 35 +++
 rtl/cdb_arbiter.sv | 100 ++++++++++
 tb/tb_cdb_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: bus sizing, FU index map, broadcast packet type.
package cdb_arbiter_pkg;

  localparam int NUM_FU_TOTAL = 5;
  localparam int CDB_TAG_W    = 6;
  localparam int XLEN         = 32;
  localparam int CDB_SRC_W    = $clog2(NUM_FU_TOTAL);

  localparam int FU_IDX_ALU    = 0;
  localparam int FU_IDX_BRANCH = 1;
  localparam int FU_IDX_MULT   = 2;
  localparam int FU_IDX_LOAD   = 3;
  localparam int FU_IDX_STORE  = 4;

  // One broadcast as seen by ROB / RS / regfile consumers.
  typedef struct packed {
    logic                 valid;
    logic [CDB_TAG_W-1:0] tag;
    logic [XLEN-1:0]      value;
    logic [CDB_SRC_W-1:0] src;
  } cdb_packet_t;

  // Round-robin successor: the slot after the winner becomes highest priority.
  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin select: first set request at or after ptr, wrapping.
// Kept generic so the RS issue select can reuse it.
module rr_arbiter #(
  parameter  int N  = 5,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan offsets 0..N-1 from ptr; the first hit wins.
  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    if (enable) begin
      for (int k = 0; k < N; k++) begin
        j = int'(ptr) + k;
        if (j >= N) j = j - N;
        if (!any && req[j]) begin
          any      = 1'b1;
          grant[j] = 1'b1;
          idx      = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one-entry holding buffer per FU, round-robin select into a
// registered broadcast stage with consumer back-pressure and global flush.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_FU_TOTAL,
  parameter int DATA_W  = XLEN,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_value,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      cdb_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_value,
  output logic [SRC_W-1:0]          cdb_src,
  output logic                      busy
);

  logic [NUM_REQ-1:0]             buf_valid;
  logic [NUM_REQ-1:0][TAG_W-1:0]  buf_tag;
  logic [NUM_REQ-1:0][DATA_W-1:0] buf_value;
  logic [NUM_REQ-1:0]             grant;
  logic [NUM_REQ-1:0]             cap;
  logic [SRC_W-1:0]               rr_ptr;
  logic [SRC_W-1:0]               win;
  logic                           win_any;
  logic                           adv;

  // The output stage can take a new result when empty or being drained.
  assign adv       = !cdb_valid || cdb_ready;
  // A slot being granted this cycle is free for a same-cycle refill.
  assign req_ready = ~buf_valid | grant;
  assign cap       = req_valid & req_ready;
  assign busy      = (|buf_valid) || cdb_valid;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req    (buf_valid),
    .ptr    (rr_ptr),
    .enable (adv),
    .grant  (grant),
    .idx    (win),
    .any    (win_any)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_buf
    // Holding buffer valid: flush clears, capture sets (wins over grant), grant clears.
    always_ff @(posedge clock or posedge reset) begin
      if (reset)          buf_valid[g] <= 1'b0;
      else if (flush)     buf_valid[g] <= 1'b0;
      else if (cap[g])    buf_valid[g] <= 1'b1;
      else if (grant[g])  buf_valid[g] <= 1'b0;
    end

    // Holding buffer payload: loaded only on an accepted, unflushed capture.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        buf_tag[g]   <= '0;
        buf_value[g] <= '0;
      end else if (!flush && cap[g]) begin
        buf_tag[g]   <= req_tag[g*TAG_W +: TAG_W];
        buf_value[g] <= req_value[g*DATA_W +: DATA_W];
      end
    end
  end

  // Broadcast register: loads the winner when advancing, empties if nothing won.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      cdb_src   <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
    end else if (adv) begin
      cdb_valid <= win_any;
      if (win_any) begin
        cdb_tag   <= buf_tag[win];
        cdb_value <= buf_value[win];
        cdb_src   <= win;
      end
    end
  end

  // Priority pointer moves past the winner; flush leaves it where it was.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      rr_ptr <= '0;
    else if (!flush && adv && win_any)
      rr_ptr <= SRC_W'(rr_next(int'(win), NUM_REQ));
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios then randomized traffic,
// checked against a queue/array reference model of the arbitration rules.
module tb_cdb_arbiter;
  localparam int N  = 5;
  localparam int DW = 32;
  localparam int TW = 6;
  localparam int SW = 3;

  logic          clock = 1'b0;
  logic          reset, flush, cdb_ready;
  logic [N-1:0]  req_valid;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_value;
  logic [N-1:0]  req_ready;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_value;
  logic [SW-1:0] cdb_src;
  logic          busy;

  cdb_arbiter dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_value(req_value),
    .req_ready(req_ready), .cdb_ready(cdb_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_src(cdb_src), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] value;
    int            src;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  bit            m_bv [N];
  logic [TW-1:0] m_bt [N];
  logic [DW-1:0] m_bd [N];
  bit            m_cv;
  int            m_ptr;
  bit            acc  [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_bv[i] = 0; m_bt[i] = '0; m_bd[i] = '0; acc[i] = 0;
    end
    m_cv  = 0;
    m_ptr = 0;
    expq.delete();
  endtask

  // Winner = first full buffer counting up from the pointer, modulo N.
  task automatic model_comb(output int g, output logic [N-1:0] rdy);
    g = -1;
    if (!m_cv || cdb_ready)
      for (int k = 0; k < N; k++)
        if (g < 0 && m_bv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    for (int i = 0; i < N; i++) rdy[i] = !m_bv[i] || (g == i);
  endtask

  task automatic model_edge();
    int g;
    logic [N-1:0] rdy;
    model_comb(g, rdy);
    for (int i = 0; i < N; i++) acc[i] = req_valid[i] && rdy[i];
    if (flush) begin
      if (m_cv && !cdb_ready) void'(expq.pop_back());
      m_cv = 0;
      for (int i = 0; i < N; i++) m_bv[i] = 0;
      return;
    end
    if (!m_cv || cdb_ready) begin
      if (g >= 0) begin
        expq.push_back('{tag: m_bt[g], value: m_bd[g], src: g});
        m_cv    = 1;
        m_bv[g] = 0;
        m_ptr   = (g + 1) % N;
      end else m_cv = 0;
    end
    for (int i = 0; i < N; i++)
      if (acc[i]) begin
        m_bv[i] = 1;
        m_bt[i] = req_tag[i*TW +: TW];
        m_bd[i] = req_value[i*DW +: DW];
      end
  endtask

  // One cycle: compare handshake/status at negedge, advance model at posedge.
  task automatic step();
    int g;
    logic [N-1:0] rdy;
    bit b;
    @(negedge clock);
    if (reset) model_reset();
    model_comb(g, rdy);
    b = m_cv;
    for (int i = 0; i < N; i++) b |= m_bv[i];
    chk("req_ready", req_ready, rdy);
    chk("cdb_valid", cdb_valid, m_cv);
    chk("busy", busy, b);
    @(posedge clock);
    if (reset) model_reset(); else model_edge();
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input int tag0, input logic [DW-1:0] val0);
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_tag[i*TW +: TW]   = TW'(tag0 + i);
      req_value[i*DW +: DW] = val0 + DW'(i);
    end
  endtask

  task automatic rnd_inputs();
    cdb_ready = ($urandom_range(0, 3) != 0);
    flush     = ($urandom_range(0, 39) == 0);
    for (int i = 0; i < N; i++) begin
      if (!(req_valid[i] && !acc[i])) begin
        req_valid[i]          = ($urandom_range(0, 2) == 0);
        req_tag[i*TW +: TW]   = TW'($urandom);
        req_value[i*DW +: DW] = $urandom;
      end
    end
  endtask

  // Monitor: each accepted broadcast must match the next expected result.
  always @(negedge clock) begin
    if (!reset && cdb_valid && cdb_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_broadcast: got tag %0h src %0d expected none at %0t",
                 cdb_tag, cdb_src, $time);
      end else begin
        mon_e = expq.pop_front();
        chk("cdb_tag", cdb_tag, mon_e.tag);
        chk("cdb_value", cdb_value, mon_e.value);
        chk("cdb_src", cdb_src, mon_e.src);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; cdb_ready = 1'b1;
    drive('0, 0, '0);
    model_reset();
    step();
    chk("rst_cdb_valid", cdb_valid, 0);
    chk("rst_req_ready", req_ready, 5'b11111);
    chk("rst_busy", busy, 0);
    chk("rst_cdb_src", cdb_src, 0);
    reset = 1'b0;
    step();

    // Single request: visible in cycle 2 only, idle after.
    drive(5'b00001, 'h0A, 32'hDEADBEEF);
    step();
    drive('0, 0, '0);
    step();
    chk("single_valid", cdb_valid, 1);
    chk("single_tag", cdb_tag, 'h0A);
    chk("single_value", cdb_value, 32'hDEADBEEF);
    chk("single_src", cdb_src, 0);
    step();
    chk("single_gone", cdb_valid, 0);
    chk("single_busy", busy, 0);

    // All five from rr_ptr=0: src order 0..4.
    reset = 1'b1; step(); reset = 1'b0;
    drive(5'b11111, 'h10, 32'h1000);
    step();
    drive('0, 0, '0);
    chk("all_ready_low", req_ready, 5'b00001);
    for (int i = 0; i < 6; i++) step();

    // Back-pressure: payload holds, second result follows release.
    drive(5'b00011, 'h20, 32'h2000);
    step();
    drive('0, 0, '0);
    step();
    cdb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_tag", cdb_tag, 'h20);
    end
    cdb_ready = 1'b1;
    step();
    chk("bp_next_src", cdb_src, 1);
    for (int i = 0; i < 3; i++) step();

    // Grant and refill of FU2 in the same cycle.
    drive(5'b00100, 'h03, 32'h3000);
    step();
    req_tag[2*TW +: TW] = 6'h11;
    req_value[2*DW +: DW] = 32'h3111;
    #1;
    chk("refill_ready", req_ready[2], 1);
    step();
    drive('0, 0, '0);
    for (int i = 0; i < 4; i++) step();

    // Flush with three full buffers and a live broadcast.
    drive(5'b01111, 'h30, 32'h4000);
    step();
    drive('0, 0, '0);
    step();
    chk("pre_flush_busy", busy, 1);
    cdb_ready = 1'b0;
    flush = 1'b1;
    drive(5'b10000, 'h3F, 32'hBAD0);
    step();
    flush = 1'b0;
    cdb_ready = 1'b1;
    drive('0, 0, '0);
    chk("flush_valid", cdb_valid, 0);
    chk("flush_busy", busy, 0);
    drive(5'b00101, 'h28, 32'h5000);
    step();
    drive('0, 0, '0);
    for (int i = 0; i < 4; i++) step();

    // Asynchronous reset during a broadcast.
    drive(5'b01000, 'h0C, 32'h6000);
    step();
    drive('0, 0, '0);
    cdb_ready = 1'b0;
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", cdb_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_ready", req_ready, 5'b11111);
    model_reset();
    cdb_ready = 1'b1;
    step();
    reset = 1'b0;
    step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rnd_inputs();
      step();
    end

    // Drain everything still held.
    flush = 1'b0;
    cdb_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < N; i++)
        if (!(req_valid[i] && !acc[i])) req_valid[i] = 1'b0;
      step();
    end
    chk("queue_empty", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
